// File: rtl/cache_pkg.sv
// cache_pkg: shared geometry, types and helpers for the 2-way L1 cache controller.
package cache_pkg;

  localparam int CACHE_ROW = 64;              // total lines
  localparam int CACHE_LEN = 8;               // bytes per line
  localparam int ADDR_L    = 32;              // byte address width

  localparam int SETS   = CACHE_ROW / 2;
  localparam int OFS_L  = $clog2(CACHE_LEN);
  localparam int IDX_L  = $clog2(SETS);
  localparam int TAG_L  = ADDR_L - IDX_L - OFS_L;
  localparam int LINE_W = 8 * CACHE_LEN;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL,
    WRITE,
    RESP
  } state_t;

  typedef logic              way_t;
  typedef logic [LINE_W-1:0] line_t;
  typedef logic [TAG_L-1:0]  tag_t;
  typedef logic [IDX_L-1:0]  idx_t;

  function automatic way_t other_way(input way_t w);
    return ~w;
  endfunction

endpackage

// File: rtl/cache_rr_arb.sv
// cache_rr_arb: two-requester round-robin arbiter. On a tie the requester that
// was not granted last wins; the history resets to "port 1 last" so port 0
// wins the first tie. Grant is one-hot and only produced while enabled.
module cache_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  logic last_grant;

  // Combinational grant selection from the request pair and the history bit.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    grant = 2'b00;
    if (en) begin
      if (req == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
      else              grant = req;
    end
  end

  // Remember which port received the most recent grant.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (rst)        last_grant <= 1'b1;
    else if (|grant) last_grant <= grant[1];
  end

endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: 2-way set-associative L1 cache controller with two requesters,
// read-miss refill, write-through without write-allocate and one outstanding
// transaction. Define CACHE_STATS_EN to build the hit/miss counters; otherwise
// hit_cnt and miss_cnt are tied to 0.
module cache_ctrl
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_L-1:0] p0_addr,
  input  line_t             p0_wdata,
  output line_t             p0_rdata,
  output logic              p0_ack,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_L-1:0] p1_addr,
  input  line_t             p1_wdata,
  output line_t             p1_rdata,
  output logic              p1_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_L-1:0] mem_addr,
  output line_t             mem_wdata,
  input  line_t             mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  state_t                state;
  logic                  cur_port;
  logic                  cur_we;
  logic [ADDR_L-1:OFS_L] cur_line;
  line_t                 cur_wdata;
  line_t                 line_buf;

  logic [1:0][SETS-1:0]  valid;
  logic [SETS-1:0]       lru;       // way to evict next in each set
  tag_t                  tag_arr  [2][SETS];
  line_t                 data_arr [2][SETS];

  tag_t       cur_tag;
  idx_t       cur_idx;
  logic [1:0] way_hit;
  logic       hit;
  way_t       hit_way;
  way_t       victim;
  logic [1:0] arb_req;
  logic [1:0] grant;
  logic       refill_done;
  logic       write_done;
  logic       arr_we;
  way_t       arr_way;
  line_t      arr_data;
  logic       unused_ofs;

  assign cur_tag = cur_line[ADDR_L-1:IDX_L+OFS_L];
  assign cur_idx = cur_line[IDX_L+OFS_L-1:OFS_L];

  // Byte offsets inside a line carry no meaning for whole-line transfers.
  assign unused_ofs = ^{p0_addr[OFS_L-1:0], p1_addr[OFS_L-1:0]};

  // A port whose ack is showing is still holding req for one more cycle; hide it.
  assign arb_req = {p1_req & ~p1_ack, p0_req & ~p0_ack};

  cache_rr_arb u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (arb_req),
    .en   (state == IDLE),
    .grant(grant)
  );

  // Memory handshakes only count while our own request is on the bus.
  assign refill_done = (state == REFILL) && mem_req && mem_ack;
  assign write_done  = (state == WRITE)  && mem_req && mem_ack;

  // Tag compare on both ways and victim choice (invalid way 0, invalid way 1, LRU).
  always_comb begin
    way_hit[0] = valid[0][cur_idx] && (tag_arr[0][cur_idx] == cur_tag);
    way_hit[1] = valid[1][cur_idx] && (tag_arr[1][cur_idx] == cur_tag);
    hit        = |way_hit;
    hit_way    = way_hit[1];
    if (!valid[0][cur_idx])      victim = 1'b0;
    else if (!valid[1][cur_idx]) victim = 1'b1;
    else                         victim = lru[cur_idx];
  end

  // Select what, if anything, is written into the tag/data arrays this cycle.
  always_comb begin
    arr_we   = 1'b0;
    arr_way  = hit_way;
    arr_data = cur_wdata;
    if (state == LOOKUP && cur_we && hit) begin
      arr_we = 1'b1;
    end else if (refill_done) begin
      arr_we   = 1'b1;
      arr_way  = victim;
      arr_data = mem_rdata;
    end
  end

  // Tag and data storage; contents are qualified by the valid bits.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays have no reset; only the valid bits need a known value.
    if (arr_we) begin
      tag_arr[arr_way][cur_idx]  <= cur_tag;
      data_arr[arr_way][cur_idx] <= arr_data;
    end
  end

  // Transaction sequencer with registered port and memory outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_port  <= 1'b0;
      cur_we    <= 1'b0;
      cur_line  <= '0;
      cur_wdata <= '0;
      line_buf  <= '0;
      valid     <= '0;
      lru       <= '0;
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (|grant) begin
            cur_port  <= grant[1];
            cur_we    <= grant[1] ? p1_we : p0_we;
            cur_line  <= grant[1] ? p1_addr[ADDR_L-1:OFS_L] : p0_addr[ADDR_L-1:OFS_L];
            cur_wdata <= grant[1] ? p1_wdata : p0_wdata;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          mem_addr  <= {cur_line, {OFS_L{1'b0}}};
          mem_we    <= cur_we;
          mem_wdata <= cur_wdata;
          if (cur_we) begin
            line_buf <= cur_wdata;
            if (hit) lru[cur_idx] <= other_way(hit_way);
            state <= WRITE;
          end else if (hit) begin
            line_buf      <= data_arr[hit_way][cur_idx];
            lru[cur_idx]  <= other_way(hit_way);
            state         <= RESP;
          end else begin
            state <= REFILL;
          end
        end
        REFILL: begin
          if (refill_done) begin
            mem_req               <= 1'b0;
            valid[victim][cur_idx] <= 1'b1;
            lru[cur_idx]          <= other_way(victim);
            line_buf              <= mem_rdata;
            state                 <= RESP;
          end else begin
            mem_req <= 1'b1;
          end
        end
        WRITE: begin
          if (write_done) begin
            mem_req <= 1'b0;
            state   <= RESP;
          end else begin
            mem_req <= 1'b1;
          end
        end
        RESP: begin
          if (cur_port) begin
            p1_ack   <= 1'b1;
            p1_rdata <= line_buf;
          end else begin
            p0_ack   <= 1'b1;
            p0_rdata <= line_buf;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  // Hit/miss statistics, classified at the tag compare; both wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (hit) hit_cnt  <= hit_cnt + 32'd1;
      else     miss_cnt <= miss_cnt + 32'd1;
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed plus randomized checks of cache_ctrl against a
// recency-list cache model, an arbitration model and a line-granular memory.
module tb_cache_ctrl;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p1_addr;
  line_t       p0_wdata, p1_wdata, p0_rdata, p1_rdata;
  logic        p0_ack, p1_ack;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr;
  line_t       mem_wdata, mem_rdata;
  logic [31:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_ack(p1_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

`ifdef CACHE_STATS_EN
  localparam logic [63:0] STAT_MASK = 64'hFFFF_FFFF;
`else
  localparam logic [63:0] STAT_MASK = 64'h0;
`endif

  typedef struct {
    bit          port;
    int          mem_kind;   // 0 none, 1 refill, 2 write-through
    logic [31:0] addr;
    line_t       wdata;
    line_t       rdata;
  } txn_t;

  int          checks = 0;
  int          failures = 0;
  txn_t        exp_q[$];
  int          mem_lat = 0;
  int          served;
  bit          first_port;
  bit          last_mem_used;
  line_t       last_rdata;

  // Model: per set, the resident lines ordered by recency (MRU, LRU).
  logic [28:0] m_mru [32];
  logic [28:0] m_lru [32];
  int          m_nres [32];
  bit          m_last;
  int unsigned m_hits, m_misses;
  line_t       m_mem [logic [28:0]];
  line_t       phys  [logic [28:0]];

  function automatic line_t init_line(input logic [28:0] l);
    return {l ^ 29'h1A2B3C4, 3'b101, ~l, 3'b010};
  endfunction

  function automatic line_t m_read(input logic [28:0] l);
    return m_mem.exists(l) ? m_mem[l] : init_line(l);
  endfunction

  function automatic line_t phys_read(input logic [28:0] l);
    return phys.exists(l) ? phys[l] : init_line(l);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_nres[i] = 0;
    m_last   = 1'b1;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic predict(input bit port);
    txn_t        t;
    logic [28:0] l;
    int          s;
    bit          res;
    bit          we;
    t.port  = port;
    t.addr  = port ? p1_addr : p0_addr;
    t.wdata = port ? p1_wdata : p0_wdata;
    we      = port ? p1_we : p0_we;
    l       = t.addr[31:3];
    s       = int'(l[4:0]);
    res     = (m_nres[s] > 0 && m_mru[s] == l) || (m_nres[s] == 2 && m_lru[s] == l);
    if (res) m_hits++; else m_misses++;
    if (we) begin
      t.mem_kind = 2;
      t.rdata    = t.wdata;
      m_mem[l]   = t.wdata;
    end else begin
      t.mem_kind = res ? 0 : 1;
      t.rdata    = m_read(l);
    end
    if (res) begin
      if (m_mru[s] != l) begin
        m_lru[s] = m_mru[s];
        m_mru[s] = l;
      end
    end else if (!we) begin
      m_lru[s] = m_mru[s];
      m_mru[s] = l;
      if (m_nres[s] < 2) m_nres[s]++;
    end
    exp_q.push_back(t);
  endtask

  // Drive clocks, play memory, and compare every ack and memory request.
  task automatic serve(input bit chk_lat);
    int   cyc = 0;
    int   since_req = 0;
    int   since_mack = -1;
    int   mcount = 0;
    bit   saw_mem = 1'b0;
    bit   prev_mreq = mem_req;
    bit   drop0 = 1'b0;
    bit   drop1 = 1'b0;
    txn_t h;
    while (exp_q.size() > 0 && cyc < 400) begin
      @(negedge clk);
      since_req++;
      if (since_mack >= 0) since_mack++;
      h = exp_q[0];
      if (mem_req && !prev_mreq) begin
        saw_mem = 1'b1;
        check("mem_we", 64'(mem_we), 64'(h.mem_kind == 2));
        check("mem_addr", 64'(mem_addr), 64'({h.addr[31:3], 3'b000}));
        if (h.mem_kind == 2) check("mem_wdata", mem_wdata, h.wdata);
        if (chk_lat) check("mem_req_latency", 64'(since_req), 64'd4);
        mcount = (mem_lat > 0) ? mem_lat : int'($urandom_range(1, 4));
      end
      prev_mreq = mem_req;
      if (p0_ack || p1_ack) begin
        check("ack_port", 64'({p1_ack, p0_ack}), h.port ? 64'd2 : 64'd1);
        check("rdata", h.port ? p1_rdata : p0_rdata, h.rdata);
        check("mem_used", 64'(saw_mem), 64'(h.mem_kind != 0));
        if (since_mack >= 0) check("ack_after_mem_ack", 64'(since_mack), 64'd3);
        else if (chk_lat)    check("hit_latency", 64'(since_req), 64'd4);
        if (served == 0) first_port = h.port;
        served++;
        last_mem_used = saw_mem;
        last_rdata    = h.port ? p1_rdata : p0_rdata;
        if (h.port) drop1 = 1'b1; else drop0 = 1'b1;
        void'(exp_q.pop_front());
        saw_mem    = 1'b0;
        since_mack = -1;
      end
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (drop0) begin p0_req = 1'b0; drop0 = 1'b0; end
      if (drop1) begin p1_req = 1'b0; drop1 = 1'b0; end
      if (mcount > 0) begin
        mcount--;
        if (mcount == 0) begin
          mem_ack = 1'b1;
          if (mem_we) phys[mem_addr[31:3]] = mem_wdata;
          else        mem_rdata = phys_read(mem_addr[31:3]);
          since_mack = 0;
        end
      end
      cyc++;
    end
    check("serve_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    p0_req = 1'b0;
    p1_req = 1'b0;
    check("hit_cnt", 64'(hit_cnt), 64'(m_hits) & STAT_MASK);
    check("miss_cnt", 64'(miss_cnt), 64'(m_misses) & STAT_MASK);
  endtask

  task automatic go(input bit r0, input bit r1, input bit chk_lat);
    served = 0;
    if (r0 && r1) begin
      if (m_last) begin predict(1'b0); predict(1'b1); end
      else        begin predict(1'b1); predict(1'b0); end
    end else begin
      predict(r1);
      m_last = r1;
    end
    p0_req = r0;
    p1_req = r1;
    serve(chk_lat);
  endtask

  task automatic rd(input bit port, input logic [31:0] a);
    if (port) begin p1_we = 1'b0; p1_addr = a; go(1'b0, 1'b1, 1'b1); end
    else      begin p0_we = 1'b0; p0_addr = a; go(1'b1, 1'b0, 1'b1); end
  endtask

  task automatic wr(input bit port, input logic [31:0] a, input line_t d);
    if (port) begin p1_we = 1'b1; p1_addr = a; p1_wdata = d; go(1'b0, 1'b1, 1'b1); end
    else      begin p0_we = 1'b1; p0_addr = a; p0_wdata = d; go(1'b1, 1'b0, 1'b1); end
  endtask

  initial begin
    int n;
    bit r0, r1;
    rst = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_p0_ack", 64'(p0_ack), 64'd0);
    check("rst_p1_ack", 64'(p1_ack), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_p0_rdata", p0_rdata, 64'd0);
    check("rst_hit_cnt", 64'(hit_cnt), 64'd0);
    check("rst_miss_cnt", 64'(miss_cnt), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Cold read miss with a fixed refill line and latency.
    phys[29'h20]  = 64'h1122334455667788;
    m_mem[29'h20] = 64'h1122334455667788;
    mem_lat = 3;
    rd(1'b0, 32'h0000_0100);
    mem_lat = 0;
    check("cold_rdata", last_rdata, 64'h1122334455667788);
    check("cold_miss_cnt", 64'(miss_cnt), 64'd1 & STAT_MASK);

    // Read hit on the same line.
    rd(1'b0, 32'h0000_0100);
    check("hit_no_mem", 64'(last_mem_used), 64'd0);
    check("hit_hit_cnt", 64'(hit_cnt), 64'd1 & STAT_MASK);

    // LRU eviction inside set 0.
    rd(1'b0, 32'h0000_0200);
    rd(1'b0, 32'h0000_0100);
    rd(1'b0, 32'h0000_0300);
    rd(1'b0, 32'h0000_0100);
    check("lru_100_hits", 64'(last_mem_used), 64'd0);
    rd(1'b1, 32'h0000_0200);
    check("lru_200_evicted", 64'(last_mem_used), 64'd1);

    // Arbitration: tie after a p1 grant goes to p0, tie after a p0 grant to p1.
    p0_we = 1'b0; p0_addr = 32'h0000_0100;
    p1_we = 1'b0; p1_addr = 32'h0000_0308;
    go(1'b1, 1'b1, 1'b0);
    check("tie1_first", 64'(first_port), 64'd0);
    rd(1'b0, 32'h0000_0100);
    p0_we = 1'b0; p0_addr = 32'h0000_0108;
    p1_we = 1'b0; p1_addr = 32'h0000_0100;
    go(1'b1, 1'b1, 1'b0);
    check("tie2_first", 64'(first_port), 64'd1);

    // Write hit, then read back the new line from the cache.
    wr(1'b1, 32'h0000_0100, 64'hDEADBEEF00000000);
    rd(1'b0, 32'h0000_0100);
    check("wr_hit_readback_no_mem", 64'(last_mem_used), 64'd0);
    check("wr_hit_readback", last_rdata, 64'hDEADBEEF00000000);

    // Write miss does not allocate.
    wr(1'b0, 32'h0000_0400, 64'h0123456789ABCDEF);
    rd(1'b0, 32'h0000_0400);
    check("wr_miss_no_alloc", 64'(last_mem_used), 64'd1);
    check("wr_miss_data", last_rdata, 64'h0123456789ABCDEF);

    // Reset while a refill is outstanding.
    p0_we = 1'b0; p0_addr = 32'h0000_0600; p0_req = 1'b1;
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("refill_reached", 64'(mem_req), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_drops_mem_req", 64'(mem_req), 64'd0);
    check("rst_drops_ack", 64'(p0_ack), 64'd0);
    p0_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    rd(1'b0, 32'h0000_0100);
    check("post_rst_miss", 64'(last_mem_used), 64'd1);

    // Randomized traffic over a few sets and tags.
    for (int i = 0; i < 80; i++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      p0_we    = ($urandom_range(0, 3) == 0);
      p0_addr  = ($urandom_range(0, 5) << 8) | ($urandom_range(0, 3) << 3) | $urandom_range(0, 7);
      p0_wdata = {$urandom, $urandom};
      p1_we    = ($urandom_range(0, 3) == 0);
      p1_addr  = ($urandom_range(0, 5) << 8) | ($urandom_range(0, 3) << 3) | $urandom_range(0, 7);
      p1_wdata = {$urandom, $urandom};
      go(r0, r1, !(r0 && r1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
